// File: rtl/lru_nway_if.sv
// rtl/lru_nway_if.sv - access, victim and flush signal bundle for lru_nway
//
// Ports (seen from the slave, i.e. the lru_nway block):
//   set_index_i          in   set addressed by access or victim request
//   valid_i, lock_i      in   per-way valid / lock bits of the addressed set
//   access_i             in   hit or fill of access_way_i, updates recency
//   access_way_i         in   way touched by access_i
//   victim_req_i         in   request a victim for set_index_i
//   lines_i              in   per-way line data, way w at [w*LINE_WIDTH +: LINE_WIDTH]
//   flush_i              in   start a recency reinitialisation sweep
//   victim_valid_o       out  one-cycle pulse, victim outputs valid
//   victim_way_o         out  chosen victim way
//   victim_all_locked_o  out  no eligible victim existed
//   evicted_line_o       out  line data of the chosen victim way
//   busy_o               out  flush sweep in progress
interface lru_nway_if #(
    parameter int WAYS       = 4,
    parameter int SETS       = 128,
    parameter int LINE_WIDTH = 512
);
    localparam int WB = $clog2(WAYS);
    localparam int SB = $clog2(SETS);

    logic [SB-1:0]              set_index_i;
    logic [WAYS-1:0]            valid_i;
    logic [WAYS-1:0]            lock_i;
    logic                       access_i;
    logic [WB-1:0]              access_way_i;
    logic                       victim_req_i;
    logic [WAYS*LINE_WIDTH-1:0] lines_i;
    logic                       flush_i;
    logic                       victim_valid_o;
    logic [WB-1:0]              victim_way_o;
    logic                       victim_all_locked_o;
    logic [LINE_WIDTH-1:0]      evicted_line_o;
    logic                       busy_o;

    modport master (
        output set_index_i, valid_i, lock_i, access_i, access_way_i,
               victim_req_i, lines_i, flush_i,
        input  victim_valid_o, victim_way_o, victim_all_locked_o,
               evicted_line_o, busy_o
    );

    modport slave (
        input  set_index_i, valid_i, lock_i, access_i, access_way_i,
               victim_req_i, lines_i, flush_i,
        output victim_valid_o, victim_way_o, victim_all_locked_o,
               evicted_line_o, busy_o
    );
endinterface

// File: rtl/lru_nway.sv
// rtl/lru_nway.sv - rank-based N-way LRU tracker with victim selection and flush sweep
//
// Ports:
//   clk_i   in  clock, rising edge
//   rst_ni  in  asynchronous active-low reset, restores initial ranks
//   bus     lru_nway_if.slave: access / victim request / flush inputs,
//           registered victim outputs and busy flag
module lru_nway #(
    parameter int WAYS       = 4,
    parameter int SETS       = 128,
    parameter int LINE_WIDTH = 512
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    lru_nway_if.slave    bus
);
    localparam int WB = $clog2(WAYS);
    localparam int SB = $clog2(SETS);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [SB-1:0] cnt_q, cnt_d;

    // rank 0 = LRU, WAYS-1 = MRU; each set always holds a permutation
    logic [WB-1:0] rank_q [SETS][WAYS];
    logic [WB-1:0] cur_rank [WAYS];
    logic [WB-1:0] acc_rank;

    logic          idle;
    logic          accept_access;
    logic          accept_victim;

    logic [WB-1:0] sel_way;
    logic          sel_none;
    logic          found_inv;
    logic [WB-1:0] best_rank;

    // flush takes priority over access and victim requests in the same cycle
    assign idle          = (state_q == IDLE);
    assign accept_access = idle && !bus.flush_i && bus.access_i;
    assign accept_victim = idle && !bus.flush_i && bus.victim_req_i;
    assign bus.busy_o    = (state_q == FLUSH);

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            cur_rank[w] = rank_q[bus.set_index_i][w];
        end
        acc_rank = rank_q[bus.set_index_i][bus.access_way_i];
    end

    // Lowest-index invalid unlocked way wins; otherwise the unlocked way with
    // the lowest rank. Ranks are unique, so ties cannot occur.
    always_comb begin
        sel_way   = '0;
        sel_none  = 1'b1;
        found_inv = 1'b0;
        best_rank = '1;
        for (int w = 0; w < WAYS; w++) begin
            if (!bus.lock_i[w]) begin
                if (!bus.valid_i[w] && !found_inv) begin
                    found_inv = 1'b1;
                    sel_way   = WB'(w);
                end else if (!found_inv && (sel_none || cur_rank[w] < best_rank)) begin
                    best_rank = cur_rank[w];
                    sel_way   = WB'(w);
                end
                sel_none = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.flush_i) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                if (cnt_q == SB'(SETS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + SB'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    rank_q[s][w] <= WB'(w);
                end
            end
        end else if (state_q == FLUSH) begin
            for (int w = 0; w < WAYS; w++) begin
                rank_q[cnt_q][w] <= WB'(w);
            end
        end else if (accept_access) begin
            // Accessing the MRU way is a no-op: no rank exceeds WAYS-1.
            for (int w = 0; w < WAYS; w++) begin
                if (WB'(w) == bus.access_way_i) begin
                    rank_q[bus.set_index_i][w] <= WB'(WAYS - 1);
                end else if (cur_rank[w] > acc_rank) begin
                    rank_q[bus.set_index_i][w] <= cur_rank[w] - WB'(1);
                end
            end
        end
    end

    // Victim uses pre-update ranks when it coincides with an access.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.victim_valid_o      <= 1'b0;
            bus.victim_way_o        <= '0;
            bus.victim_all_locked_o <= 1'b0;
            bus.evicted_line_o      <= '0;
        end else begin
            bus.victim_valid_o <= accept_victim;
            if (accept_victim) begin
                bus.victim_way_o        <= sel_way;
                bus.victim_all_locked_o <= sel_none;
                bus.evicted_line_o      <= bus.lines_i[sel_way*LINE_WIDTH +: LINE_WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_lru_nway.sv
// tb/tb_lru_nway.sv - directed self-checking bench for lru_nway
module tb_lru_nway;
    localparam int WAYS       = 4;
    localparam int SETS       = 8;
    localparam int LINE_WIDTH = 32;

    logic clk_i;
    logic rst_ni;
    int   n_tests;
    int   n_fails;
    int   busy_cycles;

    lru_nway_if #(.WAYS(WAYS), .SETS(SETS), .LINE_WIDTH(LINE_WIDTH)) bus ();

    lru_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_WIDTH(LINE_WIDTH)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic victim(input int set, input logic [3:0] valid, input logic [3:0] lock);
        bus.set_index_i  = 3'(set);
        bus.valid_i      = valid;
        bus.lock_i       = lock;
        bus.victim_req_i = 1'b1;
        step();
        bus.victim_req_i = 1'b0;
    endtask

    task automatic access(input int set, input int way);
        bus.set_index_i  = 3'(set);
        bus.access_way_i = 2'(way);
        bus.access_i     = 1'b1;
        step();
        bus.access_i     = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fails = 0;
        rst_ni           = 1'b0;
        bus.set_index_i  = '0;
        bus.valid_i      = 4'b1111;
        bus.lock_i       = 4'b0000;
        bus.access_i     = 1'b0;
        bus.access_way_i = '0;
        bus.victim_req_i = 1'b0;
        bus.flush_i      = 1'b0;
        bus.lines_i      = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        step();
        step();
        check("rst_valid", bus.victim_valid_o, 0);
        check("rst_way", bus.victim_way_o, 0);
        check("rst_locked", bus.victim_all_locked_o, 0);
        check("rst_line", bus.evicted_line_o, 0);
        check("rst_busy", bus.busy_o, 0);
        rst_ni = 1'b1;
        step();

        // first victim after reset
        victim(3, 4'b1111, 4'b0000);
        check("v0_valid", bus.victim_valid_o, 1);
        check("v0_way", bus.victim_way_o, 0);
        check("v0_line", bus.evicted_line_o, 32'hA0);
        step();
        check("v0_pulse", bus.victim_valid_o, 0);
        check("v0_hold", bus.evicted_line_o, 32'hA0);

        // recency: set 3 ranks become w3=0 w0=1 w1=2 w2=3
        access(3, 0);
        access(3, 1);
        access(3, 2);
        victim(3, 4'b1111, 4'b0000);
        check("lru_way", bus.victim_way_o, 3);
        check("lru_line", bus.evicted_line_o, 32'hA3);
        victim(4, 4'b1111, 4'b0000);
        check("other_set", bus.victim_way_o, 0);

        // MRU access leaves ranks unchanged
        access(3, 2);
        victim(3, 4'b1111, 4'b0000);
        check("mru_noop", bus.victim_way_o, 3);

        // invalid and lock handling
        victim(3, 4'b1011, 4'b0000);
        check("invalid_way", bus.victim_way_o, 2);
        check("invalid_line", bus.evicted_line_o, 32'hA2);
        victim(4, 4'b1111, 4'b0001);
        check("lock_way", bus.victim_way_o, 1);
        victim(4, 4'b1111, 4'b1111);
        check("all_locked", bus.victim_all_locked_o, 1);
        check("all_locked_way", bus.victim_way_o, 0);
        step();
        check("locked_hold", bus.victim_all_locked_o, 1);
        victim(4, 4'b0111, 4'b1000);
        check("lock_invalid_skip", bus.victim_way_o, 0);
        check("locked_clear", bus.victim_all_locked_o, 0);

        // coincident victim and access in a fresh set
        bus.set_index_i  = 3'd6;
        bus.valid_i      = 4'b1111;
        bus.lock_i       = 4'b0000;
        bus.access_way_i = 2'd0;
        bus.access_i     = 1'b1;
        bus.victim_req_i = 1'b1;
        step();
        bus.access_i     = 1'b0;
        bus.victim_req_i = 1'b0;
        check("coinc_way", bus.victim_way_o, 0);
        victim(6, 4'b1111, 4'b0000);
        check("coinc_next", bus.victim_way_o, 1);

        // set 5: access 0 then 3 -> w1=0 w2=1 w0=2 w3=3
        access(5, 0);
        access(5, 3);
        victim(5, 4'b1111, 4'b0000);
        check("pre_flush", bus.victim_way_o, 1);

        // flush wins over coincident access and victim request
        bus.set_index_i  = 3'd5;
        bus.access_way_i = 2'd1;
        bus.access_i     = 1'b1;
        bus.victim_req_i = 1'b1;
        bus.flush_i      = 1'b1;
        step();
        busy_cycles = 0;
        for (int i = 0; i < 20 && bus.busy_o; i++) begin
            busy_cycles++;
            check("flush_no_victim", bus.victim_valid_o, 0);
            step();
        end
        bus.access_i     = 1'b0;
        bus.victim_req_i = 1'b0;
        bus.flush_i      = 1'b0;
        check("flush_busy_cycles", busy_cycles, 8);
        check("flush_end_no_victim", bus.victim_valid_o, 0);
        check("flush_end_busy", bus.busy_o, 0);
        victim(5, 4'b1111, 4'b0000);
        check("post_flush_s5", bus.victim_way_o, 0);
        victim(3, 4'b1111, 4'b0000);
        check("post_flush_s3", bus.victim_way_o, 0);

        // reset mid-flush aborts the sweep
        access(2, 0);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        check("flush2_busy", bus.busy_o, 1);
        step();
        step();
        rst_ni = 1'b0;
        #1;
        check("abort_busy", bus.busy_o, 0);
        check("abort_valid", bus.victim_valid_o, 0);
        step();
        rst_ni = 1'b1;
        step();
        victim(2, 4'b1111, 4'b0000);
        check("abort_s2", bus.victim_way_o, 0);
        check("abort_s2_valid", bus.victim_valid_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end
endmodule

// File: doc/lru_nway.md
LRU_NWAY -- requirements
Module: lru_nway

Interface
REQ-001 Parameter WAYS, default 4: ways per set; power of two, at least 2; WB = $clog2(WAYS).
REQ-002 Parameter SETS, default 128: number of sets; SB = $clog2(SETS).
REQ-003 Parameter LINE_WIDTH, default 512: bits per cache line.
REQ-004 clk_i  in  1  clock, all state updates on the rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 set_index_i  in  SB  set addressed by the current access or victim request.
REQ-007 valid_i  in  WAYS  per-way valid bits of the addressed set.
REQ-008 lock_i  in  WAYS  per-way lock bits; a locked way is never chosen as victim.
REQ-009 access_i  in  1  hit or fill of access_way_i in set_index_i; updates recency.
REQ-010 access_way_i  in  WB  way touched by access_i.
REQ-011 victim_req_i  in  1  request a victim for set_index_i.
REQ-012 lines_i  in  WAYS*LINE_WIDTH  line data; way w occupies bits [w*LINE_WIDTH +: LINE_WIDTH].
REQ-013 flush_i  in  1  start a recency reinitialisation sweep of all sets.
REQ-014 victim_valid_o  out  1  one-cycle pulse; the victim outputs are valid.
REQ-015 victim_way_o  out  WB  chosen victim way.
REQ-016 victim_all_locked_o  out  1  no eligible victim exists; qualified by victim_valid_o.
REQ-017 evicted_line_o  out  LINE_WIDTH  line data of the chosen victim way.
REQ-018 busy_o  out  1  flush sweep in progress.

Function
REQ-019 Each set SHALL hold a rank per way (WB bits): 0 = LRU, WAYS-1 = MRU; the ranks of a set SHALL always form a permutation of 0..WAYS-1.
REQ-020 Initial rank SHALL be rank[s][w] = w for every set s and way w.
REQ-021 access_i with busy_o=0 SHALL apply an update at the next edge (let r = rank of access_way_i):
- every way with rank > r decrements by 1;
- access_way_i becomes WAYS-1;
- all other ways and sets are unchanged.
REQ-022 Accessing the way already at MRU SHALL leave all ranks unchanged.
REQ-023 victim_req_i with busy_o=0 SHALL select the victim combinationally from current ranks, valid_i and lock_i.
REQ-024 The selected victim SHALL appear registered on the next cycle with victim_valid_o=1 for exactly one cycle; latency is 1 and there is no back-pressure.
REQ-025 Victim selection:
- candidates are the ways with lock_i=0;
- the lowest-index invalid candidate wins;
- otherwise the candidate with the lowest rank wins.
REQ-026 With no candidate (lock_i all ones), victim_all_locked_o=1 and victim_way_o=0; otherwise victim_all_locked_o=0.
REQ-027 evicted_line_o SHALL be the lines_i slice of the selected way, sampled in the request cycle; it holds its value until the next accepted request.
REQ-028 victim_way_o and victim_all_locked_o SHALL hold their values between pulses.
REQ-029 When victim_req_i and access_i coincide in the same set, the victim SHALL use pre-update ranks and the rank update still applies at that edge.
REQ-030 Controller FSM has two states, IDLE and FLUSH:
- IDLE -> FLUSH when flush_i=1, with busy_o=1 from the next cycle;
- FLUSH writes the initial ranks to one set per cycle, set counter 0..SETS-1;
- FLUSH -> IDLE after set SETS-1 is written, so busy_o is high for exactly SETS cycles.
REQ-031 While busy_o=1, access_i, victim_req_i and flush_i SHALL be ignored and victim_valid_o SHALL be 0.
REQ-032 flush_i together with access_i or victim_req_i in IDLE: flush SHALL win and the others are ignored.

Reset
REQ-033 rst_ni low SHALL asynchronously drive:
- victim_valid_o=0, victim_way_o=0, victim_all_locked_o=0, evicted_line_o=0, busy_o=0;
- FSM to IDLE and set counter to 0;
- all ranks to the initial values (REQ-020).
REQ-034 Reset asserted mid-flush SHALL abort the sweep; the block returns to IDLE with all ranks initialised.

Verification (WAYS=4, SETS=8, LINE_WIDTH=32, lines_i way w = 32'hA0+w unless stated)
REQ-035 Reset, then victim_req set 3, valid 4'b1111, lock 0 -> next cycle victim_valid_o=1, victim_way_o=0, evicted_line_o=32'hA0.
REQ-036 Access set 3 ways 0,1,2, then victim_req set 3 -> way 3, line 32'hA3; a victim_req to set 4 still returns way 0.
REQ-037 valid 4'b1011 with any ranks -> victim way 2; lock 4'b0001 after reset -> way 1; lock 4'b1111 -> victim_all_locked_o=1, victim_way_o=0.
REQ-038 victim_req and access of way 0 in set 3 in the same cycle after reset -> victim way 0 reported; the next request returns way 1.
REQ-039 Access set 5 way 3, then flush_i -> busy_o high for exactly 8 cycles with victim_req and access ignored and no victim_valid_o; afterwards a set 5 request returns way 0.
REQ-040 Reset asserted 3 cycles into a flush -> busy_o=0 immediately; the first request after release returns way 0.
